// File: rtl/calc_out_delay.sv
// calc_out_delay: per-port programmable output retiming for the calc family.
// Each port owns a MAX_DELAY-stage {data, resp} shift line. A tap selects the
// output at 0..MAX_DELAY cycles of delay. Delay 0 is a combinational
// pass-through. In skew mode only the data is delayed, and the response
// passes straight through. New settings are held pending until the port's
// response line is empty, so no in-flight response is lost or duplicated.
// Port numbering: cfg_port index i addresses port i+1. Port 1 is the
// leftmost (most significant) slice, so index i uses slice NUM_PORTS-1-i.
module calc_out_delay #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = 32,
   parameter int RESP_W     = 2,
   parameter int MAX_DELAY  = 4,
   localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int DLY_W     = $clog2(MAX_DELAY + 1)
) (
   input  logic                          c_clk,
   input  logic                          reset,
   input  logic                          cfg_wr,
   input  logic [PORT_W-1:0]             cfg_port,
   input  logic [DLY_W-1:0]              cfg_delay,
   input  logic                          cfg_mode,
   output logic                          cfg_busy,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   input  logic [NUM_PORTS*RESP_W-1:0]   in_resp,
   output logic [NUM_PORTS*DATA_W-1:0]   out_data,
   output logic [NUM_PORTS*RESP_W-1:0]   out_resp
);

   localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);

   // Requested delay clamped to the longest line available.
   logic [DLY_W-1:0] wr_delay;
   assign wr_delay = (cfg_delay > MAX_D) ? MAX_D : cfg_delay;

   logic [NUM_PORTS-1:0] pend_vec;

   // Busy while any port still waits to take its new setting.
   assign cfg_busy = reset ? 1'b0 : (|pend_vec);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         localparam int SL = NUM_PORTS - 1 - gi;

         logic [DATA_W-1:0] data_line_reg [MAX_DELAY];
         logic [RESP_W-1:0] resp_line_reg [MAX_DELAY];
         logic [DATA_W-1:0] tap_data      [MAX_DELAY+1];
         logic [RESP_W-1:0] tap_resp      [MAX_DELAY+1];

         logic [DLY_W-1:0]  act_d_reg;
         logic              act_m_reg;
         logic [DLY_W-1:0]  pend_d_reg;
         logic              pend_m_reg;
         logic              pend_reg;

         logic [DATA_W-1:0] port_data;
         logic [RESP_W-1:0] port_resp;
         logic              wr_hit;
         logic              line_idle;
         logic              apply_now;

         assign port_data = in_data[SL*DATA_W +: DATA_W];
         assign port_resp = in_resp[SL*RESP_W +: RESP_W];

         // Out-of-range port indices never match any port, so they are dropped.
         assign wr_hit    = cfg_wr && !reset && (cfg_port == PORT_W'(gi));
         // A write on the same edge replaces the old pending value instead of applying it.
         assign apply_now = pend_reg && line_idle && !wr_hit;
         assign pend_vec[gi] = pend_reg;

         // The line counts as drained when no response is held in any stage.
         always_comb begin
            line_idle = 1'b1;
            for (int k = 0; k < MAX_DELAY; k++) begin
               if (resp_line_reg[k] != '0) line_idle = 1'b0;
            end
         end

         // Tap 0 is the live input; tap k is the output of stage k-1.
         always_comb begin
            tap_data[0] = port_data;
            tap_resp[0] = port_resp;
            for (int k = 0; k < MAX_DELAY; k++) begin
               tap_data[k+1] = data_line_reg[k];
               tap_resp[k+1] = resp_line_reg[k];
            end
         end

         // Free-running shift line; reset throws away everything in flight.
         always_ff @(posedge c_clk) begin
            if (reset) begin
               for (int k = 0; k < MAX_DELAY; k++) begin
                  data_line_reg[k] <= '0;
                  resp_line_reg[k] <= '0;
               end
            end else begin
               data_line_reg[0] <= port_data;
               resp_line_reg[0] <= port_resp;
               for (int k = 1; k < MAX_DELAY; k++) begin
                  data_line_reg[k] <= data_line_reg[k-1];
                  resp_line_reg[k] <= resp_line_reg[k-1];
               end
            end
         end

         // Pending/active settings: capture writes, promote once drained.
         always_ff @(posedge c_clk) begin
            if (reset) begin
               act_d_reg  <= '0;
               act_m_reg  <= 1'b0;
               pend_d_reg <= '0;
               pend_m_reg <= 1'b0;
               pend_reg   <= 1'b0;
            end else begin
               if (apply_now) begin
                  act_d_reg <= pend_d_reg;
                  act_m_reg <= pend_m_reg;
               end
               if (wr_hit) begin
                  pend_d_reg <= wr_delay;
                  pend_m_reg <= cfg_mode;
                  pend_reg   <= 1'b1;
               end else if (apply_now) begin
                  pend_reg   <= 1'b0;
               end
            end
         end

         // Outputs are held at zero while reset is asserted.
         assign out_data[SL*DATA_W +: DATA_W] = reset ? '0 : tap_data[act_d_reg];
         assign out_resp[SL*RESP_W +: RESP_W] = reset ? '0 :
                                                (act_m_reg ? port_resp : tap_resp[act_d_reg]);
      end
   endgenerate

endmodule

// File: tb/tb_calc_out_delay.sv
// Directed bench for calc_out_delay: reset, pass-through, aligned and skewed
// delay, deferred apply, overwrite/clamp, invalid port, and reset mid-flight.
module tb_calc_out_delay;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int RW = 2;

   logic c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   logic           reset;
   logic           cfg_wr;
   logic [1:0]     cfg_port;
   logic [2:0]     cfg_delay;
   logic           cfg_mode;
   logic           cfg_busy;
   logic [127:0]   in_data;
   logic [7:0]     in_resp;
   logic [127:0]   out_data;
   logic [7:0]     out_resp;

   // Second instance with a non-power-of-two port count for the invalid-index case.
   logic           cfg3_wr;
   logic [1:0]     cfg3_port;
   logic [2:0]     cfg3_delay;
   logic           cfg3_mode;
   logic           cfg3_busy;
   logic [95:0]    in_data3;
   logic [5:0]     in_resp3;
   logic [95:0]    out_data3;
   logic [5:0]     out_resp3;

   int vec_cnt = 0;
   int err_cnt = 0;

   calc_out_delay #(.NUM_PORTS(4), .DATA_W(32), .RESP_W(2), .MAX_DELAY(4)) dut (
      .c_clk(c_clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_port(cfg_port),
      .cfg_delay(cfg_delay), .cfg_mode(cfg_mode), .cfg_busy(cfg_busy),
      .in_data(in_data), .in_resp(in_resp), .out_data(out_data), .out_resp(out_resp)
   );

   calc_out_delay #(.NUM_PORTS(3), .DATA_W(32), .RESP_W(2), .MAX_DELAY(4)) dut3 (
      .c_clk(c_clk), .reset(reset), .cfg_wr(cfg3_wr), .cfg_port(cfg3_port),
      .cfg_delay(cfg3_delay), .cfg_mode(cfg3_mode), .cfg_busy(cfg3_busy),
      .in_data(in_data3), .in_resp(in_resp3), .out_data(out_data3), .out_resp(out_resp3)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("  ok %s got=%h", tag, got);
      end
   endtask

   function automatic logic [31:0] od(input int idx);
      return out_data[(NP-1-idx)*DW +: DW];
   endfunction

   function automatic logic [1:0] orsp(input int idx);
      return out_resp[(NP-1-idx)*RW +: RW];
   endfunction

   task automatic drive(input int idx, input logic [31:0] d, input logic [1:0] r);
      in_data[(NP-1-idx)*DW +: DW] = d;
      in_resp[(NP-1-idx)*RW +: RW] = r;
   endtask

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   task automatic drain();
      in_data = '0;
      in_resp = '0;
      repeat (6) step();
   endtask

   // Write a setting into an idle port and let it activate on the next edge.
   task automatic configure(input int p, input int d, input logic m);
      cfg_wr    = 1'b1;
      cfg_port  = p[1:0];
      cfg_delay = d[2:0];
      cfg_mode  = m;
      step();
      cfg_wr    = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      cfg_wr = 1'b1; cfg_port = 2'd0; cfg_delay = 3'd2; cfg_mode = 1'b1;
      in_data = '0; in_resp = '0;
      cfg3_wr = 1'b0; cfg3_port = '0; cfg3_delay = '0; cfg3_mode = 1'b0;
      in_data3 = '0; in_resp3 = '0;
      drive(2, 32'hDEAD_BEEF, 2'b01);
      #1;
      check_val("rst_data3", od(2), 32'h0);
      check_val("rst_resp3", orsp(2), 2'b00);
      check_val("rst_busy", cfg_busy, 1'b0);
      step();
      step();

      // Reset released: d=0 pass-through, write during reset ignored.
      reset = 1'b0;
      cfg_wr = 1'b0;
      #1;
      check_val("pass_data3", od(2), 32'hDEAD_BEEF);
      check_val("pass_resp3", orsp(2), 2'b01);
      step();
      check_val("rst_wr_ignored", cfg_busy, 1'b0);
      drain();

      // Aligned delay: port 1 (index 0), d=3.
      cfg_wr = 1'b1; cfg_port = 2'd0; cfg_delay = 3'd3; cfg_mode = 1'b0;
      step();
      cfg_wr = 1'b0;
      check_val("al_busy_rise", cfg_busy, 1'b1);
      step();
      check_val("al_busy_fall", cfg_busy, 1'b0);
      for (int i = 0; i < 6; i++) begin
         drive(0, (i == 0) ? 32'h11 : 32'h0, (i == 0) ? 2'b01 : 2'b00);
         #1;
         check_val($sformatf("al_resp_c%0d", i), orsp(0), (i == 3) ? 2'b01 : 2'b00);
         check_val($sformatf("al_data_c%0d", i), od(0), (i == 3) ? 32'h11 : 32'h0);
         step();
      end
      drain();

      // Skew mode: port 2 (index 1), d=1, resp passes straight through.
      configure(1, 1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1, (i == 0) ? 32'hA5A5_A5A5 : 32'h0, (i == 0) ? 2'b10 : 2'b00);
         #1;
         check_val($sformatf("sk_resp_c%0d", i), orsp(1), (i == 0) ? 2'b10 : 2'b00);
         check_val($sformatf("sk_data_c%0d", i), od(1), (i == 1) ? 32'hA5A5_A5A5 : 32'h0);
         step();
      end
      drain();

      // Deferred apply: d=4 with a response in flight, then request d=0.
      configure(0, 4, 1'b0);
      for (int i = 0; i < 7; i++) begin
         drive(0, (i == 0) ? 32'h22 : 32'h0, (i == 0) ? 2'b01 : 2'b00);
         cfg_wr = (i == 1);
         cfg_port = 2'd0; cfg_delay = 3'd0; cfg_mode = 1'b0;
         #1;
         check_val($sformatf("df_resp_c%0d", i), orsp(0), (i == 4) ? 2'b01 : 2'b00);
         check_val($sformatf("df_data_c%0d", i), od(0), (i == 4) ? 32'h22 : 32'h0);
         check_val($sformatf("df_busy_c%0d", i), cfg_busy, (i >= 2 && i <= 5));
         step();
      end
      cfg_wr = 1'b0;
      drive(0, 32'h33, 2'b00);
      #1;
      check_val("df_new_d0", od(0), 32'h33);
      drain();

      // Overwrite and clamp: port 3 (index 2), d=2 m=1 then d=7 m=0 -> d=4 m=0.
      cfg_wr = 1'b1; cfg_port = 2'd2; cfg_delay = 3'd2; cfg_mode = 1'b1;
      step();
      cfg_delay = 3'd7; cfg_mode = 1'b0;
      step();
      cfg_wr = 1'b0;
      check_val("ow_still_busy", cfg_busy, 1'b1);
      step();
      check_val("ow_busy_fall", cfg_busy, 1'b0);
      for (int i = 0; i < 6; i++) begin
         drive(2, (i == 0) ? 32'h44 : 32'h0, (i == 0) ? 2'b10 : 2'b00);
         #1;
         check_val($sformatf("ow_data_c%0d", i), od(2), (i == 4) ? 32'h44 : 32'h0);
         check_val($sformatf("ow_resp_c%0d", i), orsp(2), (i == 4) ? 2'b10 : 2'b00);
         step();
      end
      drain();

      // Invalid port index on a 3-port instance is dropped; a valid one is not.
      cfg3_wr = 1'b1; cfg3_port = 2'd3; cfg3_delay = 3'd2; cfg3_mode = 1'b0;
      step();
      cfg3_wr = 1'b0;
      check_val("inv_busy", cfg3_busy, 1'b0);
      in_data3 = {32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
      #1;
      check_val("inv_pass_p1", out_data3[95:64], 32'h1111_0001);
      check_val("inv_pass_p3", out_data3[31:0], 32'h3333_0003);
      cfg3_wr = 1'b1; cfg3_port = 2'd2; cfg3_delay = 3'd1;
      step();
      cfg3_wr = 1'b0;
      check_val("val3_busy", cfg3_busy, 1'b1);
      in_data3 = '0;
      drain();

      // Reset mid-flight: queued responses on port 1 never appear.
      configure(0, 4, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive(0, 32'h66, 2'b01);
         step();
      end
      reset = 1'b1;
      drive(0, 32'h0, 2'b00);
      drive(1, 32'h99, 2'b11);
      #1;
      check_val("mr_rst_resp2", orsp(1), 2'b00);
      check_val("mr_rst_data1", od(0), 32'h0);
      step();
      reset = 1'b0;
      drive(1, 32'h0, 2'b00);
      drive(0, 32'h77, 2'b00);
      #1;
      check_val("mr_d0_pass", od(0), 32'h77);
      check_val("mr_busy", cfg_busy, 1'b0);
      step();
      for (int i = 0; i < 6; i++) begin
         drive(0, 32'h0, 2'b00);
         #1;
         check_val($sformatf("mr_resp_c%0d", i), orsp(0), 2'b00);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
